piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_serializer.sv | 114 +++++++++++
 tb/tb_piso_serializer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in serial-out serializer.
// Defining SER_PARITY_EN adds the PARITY state used for the trailing even-parity bit.
package piso_pkg;

    localparam int DEFAULT_DATA_W = 8;

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, MSB first, with a valid/ready load side and a stallable sink.
// Defining SER_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              shift_enable,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              busy,
    output logic              done
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              done_q;
    logic              accept;
    logic              shift_fire;
    logic              frame_end;
`ifdef SER_PARITY_EN
    logic              parity_q;
`endif

    // NOTE: every output of this block gets a default before the case; a
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt    = state;
        load_ready   = 1'b0;
        serial_valid = 1'b0;
        serial_out   = 1'b0;
        busy         = 1'b0;
        accept       = 1'b0;
        shift_fire   = 1'b0;
        frame_end    = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                accept     = load_valid;
                if (load_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                serial_valid = 1'b1;
                busy         = 1'b1;
                serial_out   = shreg[DATA_W-1];
                shift_fire   = shift_enable;
                if (shift_enable && bit_cnt == LAST_BIT) begin
`ifdef SER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                serial_valid = 1'b1;
                busy         = 1'b1;
                serial_out   = parity_q;
                if (shift_enable) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // done is registered from the leaving transition, so it lands on the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            done_q   <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= frame_end;
            if (accept) begin
                shreg    <= load_data;
                bit_cnt  <= '0;
`ifdef SER_PARITY_EN
                parity_q <= ^load_data;
`endif
            end else if (shift_fire) begin
                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: expected bits go into a scoreboard queue at load time
// and are compared as the sink consumes them. Honours SER_PARITY_EN for the frame length.
module tb_piso_serializer;

    localparam int DATA_W = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = DATA_W + 1;
`else
    localparam int FRAME = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
    logic              shift_enable;
    logic              serial_out;
    logic              serial_valid;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    bit sb[$];

    piso_serializer #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .shift_enable (shift_enable),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are Moore-style, so sampling just after the edge is safe.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        for (int i = DATA_W - 1; i >= 0; i--) sb.push_back(w[i]);
`ifdef SER_PARITY_EN
        sb.push_back(^w);
`endif
    endtask

    task automatic check_bit(input string tag);
        if (sb.size() == 0) check({tag, ":extra_bit"}, serial_valid, 0);
        else                check({tag, ":bit"}, serial_out, sb[0]);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ":load_ready"},   load_ready,   1);
        check({tag, ":serial_valid"}, serial_valid, 0);
        check({tag, ":serial_out"},   serial_out,   0);
        check({tag, ":busy"},         busy,         0);
    endtask

    // Sends one word from an IDLE cycle; holds shift_enable low for stall_len cycles
    // while the bit with index stall_at (0 = MSB) is on the line.
    task automatic send_word(input logic [DATA_W-1:0] w, input int stall_at,
                             input int stall_len, input string tag);
        int exp_done;
        int shifts;
        int stalled;
        int cyc;
        bit seen_done;
        exp_done  = FRAME + 1 + stall_len;
        shifts    = 0;
        stalled   = 0;
        seen_done = 0;
        cyc       = 1;
        check({tag, ":ready"}, load_ready, 1);
        push_word(w);
        load_data    = w;
        load_valid   = 1'b1;
        shift_enable = 1'b1;
        step();
        load_valid = 1'b0;
        while (!seen_done && cyc <= exp_done + 4) begin
            if (done) begin
                seen_done = 1;
                check({tag, ":done_cycle"}, cyc, exp_done);
                check({tag, ":done_valid"}, serial_valid, 0);
            end else begin
                check({tag, ":valid"}, serial_valid, 1);
                check({tag, ":busy"},  busy,         1);
                check({tag, ":ready"}, load_ready,   0);
                check_bit(tag);
                if (shifts == stall_at && stalled < stall_len) begin
                    shift_enable = 1'b0;
                    stalled++;
                end else begin
                    shift_enable = 1'b1;
                    if (sb.size() > 0) void'(sb.pop_front());
                    shifts++;
                end
                step();
                cyc++;
            end
        end
        check({tag, ":done_seen"}, seen_done, 1);
        check({tag, ":shifts"},    shifts,    FRAME);
        step();
        check({tag, ":done_len"},  done,      0);
    endtask

    initial begin
        int bits;
        reset        = 1'b1;
        load_data    = '0;
        load_valid   = 1'b0;
        shift_enable = 1'b0;

        // Reset held for two cycles.
        step();
        step();
        check_idle("reset");
        check("reset:done", done, 0);
        reset = 1'b0;

        // shift_enable alone in IDLE must not start anything.
        shift_enable = 1'b1;
        step();
        check_idle("idle_shift");
        check("idle_shift:done", done, 0);

        send_word(8'b1011_0010, -1, 0, "w_b2");
        send_word(8'hA5, 2, 3, "w_a5_stall");

        // Back-to-back: load_valid held with 8'h01 while 8'hFF is in flight.
        push_word(8'hFF);
        push_word(8'h01);
        load_data    = 8'hFF;
        load_valid   = 1'b1;
        shift_enable = 1'b1;
        step();
        load_data = 8'h01;
        bits      = 0;
        for (int cyc = 1; cyc <= 2 * FRAME + 2; cyc++) begin
            if (cyc == FRAME + 1 || cyc == 2 * FRAME + 2) begin
                check("b2b:done",  done,         1);
                check("b2b:ready", load_ready,   1);
                check("b2b:valid", serial_valid, 0);
            end else begin
                check("b2b:no_done", done, 0);
                check("b2b:valid",   serial_valid, 1);
                check_bit("b2b");
                if (sb.size() > 0) void'(sb.pop_front());
                bits++;
            end
            if (cyc == FRAME + 2) load_valid = 1'b0;
            if (cyc < 2 * FRAME + 2) step();
        end
        check("b2b:bits", bits, 2 * FRAME);
        step();
        check("b2b:done_len", done, 0);
        check_idle("b2b:after");

        // Reset after four bits of 8'hC3, colliding with load_valid and shift_enable.
        push_word(8'hC3);
        load_data    = 8'hC3;
        load_valid   = 1'b1;
        shift_enable = 1'b1;
        step();
        load_valid = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            check_bit("abort");
            if (sb.size() > 0) void'(sb.pop_front());
            step();
        end
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h55;
        step();
        check_idle("abort:reset");
        check("abort:done", done, 0);
        reset      = 1'b0;
        load_valid = 1'b0;
        sb.delete();
        step();
        check_idle("abort:no_capture");
        check("abort:no_done", done, 0);
        send_word(8'h3C, -1, 0, "w_3c");

`ifdef SER_PARITY_EN
        send_word(8'b0000_0111, -1, 0, "w_par07");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
